// File: rtl/phys_free_list_if.sv
// Rename-side / commit-side port bundle for the physical register free list.
// The free list itself connects through the slave modport; the pipeline (or a
// bench) drives the master side.
interface phys_free_list_if #(
    parameter int unsigned PR_W   = 6,
    parameter int unsigned NUM_PR = 32
);
    localparam int unsigned CT_W = $clog2(NUM_PR) + 1;

    logic [2:0]        alloc_ct;
    logic [4*PR_W-1:0] alloc_regs;
    logic              alloc_grant;
    logic [CT_W-1:0]   free_ct;
    logic [6*PR_W-1:0] free_regs;
    logic [5:0]        free_valid;
    logic [2:0]        retire_ct;
    logic              flush;
    logic              err;

    modport master (
        output alloc_ct, free_regs, free_valid, retire_ct, flush,
        input  alloc_regs, alloc_grant, free_ct, err
    );

    modport slave (
        input  alloc_ct, free_regs, free_valid, retire_ct, flush,
        output alloc_regs, alloc_grant, free_ct, err
    );
endinterface

// File: rtl/phys_free_list.sv
// Physical register free list: circular array of free register numbers with a
// speculative allocation head, an architectural (retired) head and a push tail.
// Hands out up to 4 registers per cycle, takes back up to 6 per cycle, and
// rolls speculative allocations back to the retired point on flush.
// Optional duplicate-free checking is enabled by defining FREE_LIST_DUPCHK_EN.
module phys_free_list #(
    parameter int unsigned PR_W     = 6,
    parameter int unsigned NUM_PR   = 32,
    parameter int unsigned RESERVED = 5
) (
    input  logic            clk,
    input  logic            rst,
    phys_free_list_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_PR);
    localparam int unsigned PTR_W = IDX_W + 1;
    // Capacity in a width one wider than a pointer, for the overflow compare.
    localparam logic [PTR_W:0] CAP = (PTR_W + 1)'(NUM_PR);

    typedef logic [PR_W-1:0]  preg_t;
    typedef logic [PTR_W-1:0] ptr_t;

    preg_t entry_q [NUM_PR];
    preg_t entry_d [NUM_PR];
    ptr_t  tail_q, tail_d;
    ptr_t  spec_head_q, spec_head_d;
    ptr_t  arch_head_q, arch_head_d;
    ptr_t  free_ct_q, free_ct_d;
    logic  err_q, err_d;

    preg_t            lane_reg [6];
    logic [5:0]       push_valid;
    logic             dup_err;
    logic [2:0]       push_ct;
    logic             overflow;
    logic             over_retire;
    logic             grant;
    ptr_t             alloc_p, retire_p, push_p, in_flight;
    logic [2:0]       push_off;
    logic [IDX_W-1:0] widx;

    // Unpack the commit lanes into an array for easier indexing.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            lane_reg[k] = bus.free_regs[k*PR_W +: PR_W];
        end
    end

`ifdef FREE_LIST_DUPCHK_EN
    logic [NUM_PR-1:0] is_free_q, is_free_d;
    logic              any_alloc_q, any_alloc_d;
    logic [PTR_W-1:0]  roll_ct;
    logic [IDX_W-1:0]  bidx;

    // Drop lanes naming a register that is already free, out of range, a
    // reserved register before anything was ever renamed, or repeated in-cycle.
    always_comb begin
        push_valid = bus.free_valid;
        for (int k = 0; k < 6; k++) begin
            if (bus.free_valid[k]) begin
                if (32'(lane_reg[k]) >= NUM_PR) begin
                    push_valid[k] = 1'b0;
                end else if (is_free_q[lane_reg[k][IDX_W-1:0]]) begin
                    push_valid[k] = 1'b0;
                end else if ((32'(lane_reg[k]) < RESERVED) && !any_alloc_q) begin
                    push_valid[k] = 1'b0;
                end
                for (int j = 0; j < k; j++) begin
                    if (bus.free_valid[j] && (lane_reg[j] == lane_reg[k])) begin
                        push_valid[k] = 1'b0;
                    end
                end
            end
        end
        dup_err = |(bus.free_valid & ~push_valid);
    end

    // Bitmap upkeep: clear on grant, set on accepted push, set again on rollback.
    always_comb begin
        is_free_d   = is_free_q;
        any_alloc_d = any_alloc_q | grant;
        roll_ct     = spec_head_q - arch_head_d;
        bidx        = '0;
        if (grant) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < bus.alloc_ct) begin
                    bidx = entry_q[spec_head_q[IDX_W-1:0] + IDX_W'(i)][IDX_W-1:0];
                    is_free_d[bidx] = 1'b0;
                end
            end
        end
        if (!overflow) begin
            for (int k = 0; k < 6; k++) begin
                if (push_valid[k]) begin
                    is_free_d[lane_reg[k][IDX_W-1:0]] = 1'b1;
                end
            end
        end
        if (bus.flush) begin
            for (int i = 0; i < NUM_PR; i++) begin
                if (PTR_W'(i) < roll_ct) begin
                    bidx = entry_q[arch_head_d[IDX_W-1:0] + IDX_W'(i)][IDX_W-1:0];
                    is_free_d[bidx] = 1'b1;
                end
            end
        end
    end

    // Bitmap state; reserved registers start out architecturally mapped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_PR; i++) begin
                is_free_q[i] <= (i >= RESERVED);
            end
            any_alloc_q <= 1'b0;
        end else begin
            is_free_q   <= is_free_d;
            any_alloc_q <= any_alloc_d;
        end
    end
`else
    // Without checking every valid lane is pushed.
    always_comb begin
        push_valid = bus.free_valid;
        dup_err    = 1'b0;
    end
`endif

    // Count accepted lanes and detect a push that would overfill the array.
    always_comb begin
        push_ct = '0;
        for (int k = 0; k < 6; k++) begin
            push_ct = push_ct + {2'b00, push_valid[k]};
        end
        overflow = ({1'b0, free_ct_q} + (PTR_W + 1)'(push_ct)) > CAP;
    end

    // Pointer, count and error next state; grant is decided on pre-free count.
    always_comb begin
        alloc_p     = PTR_W'(bus.alloc_ct);
        retire_p    = PTR_W'(bus.retire_ct);
        push_p      = PTR_W'(push_ct);
        in_flight   = spec_head_q - arch_head_q;
        grant       = (bus.alloc_ct != 3'd0) && (alloc_p <= free_ct_q) && !bus.flush;
        over_retire = retire_p > in_flight;
        arch_head_d = over_retire ? spec_head_q : arch_head_q + retire_p;
        if (bus.flush) begin
            spec_head_d = arch_head_d;
        end else if (grant) begin
            spec_head_d = spec_head_q + alloc_p;
        end else begin
            spec_head_d = spec_head_q;
        end
        tail_d    = overflow ? tail_q : tail_q + push_p;
        free_ct_d = tail_d - spec_head_d;
        err_d     = err_q | overflow | over_retire | dup_err;
    end

    // Compact accepted lanes in ascending order starting at the tail.
    always_comb begin
        entry_d  = entry_q;
        push_off = '0;
        widx     = '0;
        for (int k = 0; k < 6; k++) begin
            if (push_valid[k]) begin
                widx = tail_q[IDX_W-1:0] + IDX_W'(push_off);
                if (!overflow) begin
                    entry_d[widx] = lane_reg[k];
                end
                push_off = push_off + 3'd1;
            end
        end
    end

    // Next four allocatable registers, lane 0 oldest.
    always_comb begin
        bus.alloc_regs = '0;
        for (int k = 0; k < 4; k++) begin
            bus.alloc_regs[k*PR_W +: PR_W] = entry_q[spec_head_q[IDX_W-1:0] + IDX_W'(k)];
        end
        bus.alloc_grant = grant;
        bus.free_ct     = free_ct_q;
        bus.err         = err_q;
    end

    // Array and pointer state; reset loads RESERVED..NUM_PR-1 in order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_PR; i++) begin
                entry_q[i] <= (i < NUM_PR - RESERVED) ? PR_W'(i + RESERVED) : '0;
            end
            tail_q      <= PTR_W'(NUM_PR - RESERVED);
            spec_head_q <= '0;
            arch_head_q <= '0;
            free_ct_q   <= PTR_W'(NUM_PR - RESERVED);
            err_q       <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            tail_q      <= tail_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            free_ct_q   <= free_ct_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed scenarios followed by a randomized run,
// all checked against a queue-based model of the free list.
module tb_phys_free_list;
    localparam int unsigned PR_W     = 6;
    localparam int unsigned NUM_PR   = 32;
    localparam int unsigned RESERVED = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    phys_free_list_if #(.PR_W(PR_W), .NUM_PR(NUM_PR)) bus_if ();

    phys_free_list #(
        .PR_W     (PR_W),
        .NUM_PR   (NUM_PR),
        .RESERVED (RESERVED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: free list in allocation order, unretired allocations oldest first,
    // and a pool of committed registers that may legally be freed again.
    int m_list[$];
    int m_inflight[$];
    int m_held[$];
    bit m_err;
    bit m_any_alloc;
    int m_pushed_total;

    int zregs [6] = '{0, 0, 0, 0, 0, 0};
    int rregs [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_q(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_list.delete();
        m_inflight.delete();
        m_held.delete();
        for (int r = RESERVED; r < NUM_PR; r++) m_list.push_back(r);
        m_err          = 1'b0;
        m_any_alloc    = 1'b0;
        m_pushed_total = 0;
    endtask

    task automatic drive_idle();
        bus_if.alloc_ct   = '0;
        bus_if.free_valid = '0;
        bus_if.free_regs  = '0;
        bus_if.retire_ct  = '0;
        bus_if.flush      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One cycle: drive at negedge, check grant before the edge, update the
    // model at the edge, check registered outputs at the next negedge.
    task automatic step(input int a_ct, input logic [5:0] fv, input int regs [6],
                        input int ret, input bit fl);
        int  pushed[$];
        int  pre_free;
        int  ret_n;
        bit  exp_grant;
        bit  ok;
        bus_if.alloc_ct   = 3'(a_ct);
        bus_if.free_valid = fv;
        for (int k = 0; k < 6; k++) bus_if.free_regs[k*PR_W +: PR_W] = PR_W'(regs[k]);
        bus_if.retire_ct  = 3'(ret);
        bus_if.flush      = fl;
        exp_grant = (a_ct != 0) && (a_ct <= m_list.size()) && !fl;
        #1;
        chk("alloc_grant", 32'(bus_if.alloc_grant), 32'(exp_grant));
        @(posedge clk);
        pre_free = m_list.size();
        for (int k = 0; k < 6; k++) begin
            if (fv[k]) begin
                ok = 1'b1;
`ifdef FREE_LIST_DUPCHK_EN
                if (in_q(m_list, regs[k]) || in_q(pushed, regs[k]) ||
                    (regs[k] < RESERVED && !m_any_alloc)) begin
                    ok    = 1'b0;
                    m_err = 1'b1;
                end
`endif
                if (ok) pushed.push_back(regs[k]);
            end
        end
        if (pre_free + pushed.size() > NUM_PR) begin
            m_err = 1'b1;
            pushed.delete();
        end else begin
            m_pushed_total += pushed.size();
        end
        if (exp_grant) begin
            repeat (a_ct) m_inflight.push_back(m_list.pop_front());
            if (!m_any_alloc) begin
                m_any_alloc = 1'b1;
                for (int r = 0; r < RESERVED; r++) m_held.push_back(r);
            end
        end
        ret_n = ret;
        if (ret > m_inflight.size()) begin
            m_err = 1'b1;
            ret_n = m_inflight.size();
        end
        repeat (ret_n) m_held.push_back(m_inflight.pop_front());
        if (fl) begin
            m_list = {m_inflight, m_list};
            m_inflight.delete();
        end
        foreach (pushed[i]) m_list.push_back(pushed[i]);
        @(negedge clk);
        chk("free_ct", 32'(bus_if.free_ct), 32'(m_list.size()));
        chk("err", 32'(bus_if.err), 32'(m_err));
        for (int k = 0; k < 4; k++) begin
            if (k < m_list.size()) begin
                chk($sformatf("alloc_regs_lane%0d", k),
                    32'(bus_if.alloc_regs[k*PR_W +: PR_W]), 32'(m_list[k]));
            end
        end
    endtask

    function automatic int lane(input int k);
        logic [4*PR_W-1:0] v;
        v = bus_if.alloc_regs;
        return int'(v[k*PR_W +: PR_W]);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive_idle();
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset state.
        #1;
        chk("reset_free_ct", 32'(bus_if.free_ct), 32'd27);
        chk("reset_lane0", 32'(lane(0)), 32'd5);
        chk("reset_lane1", 32'(lane(1)), 32'd6);
        chk("reset_lane2", 32'(lane(2)), 32'd7);
        chk("reset_lane3", 32'(lane(3)), 32'd8);
        chk("reset_err", 32'(bus_if.err), 32'd0);
        chk("reset_grant", 32'(bus_if.alloc_grant), 32'd0);
        @(negedge clk);

        // Drain by fours, then one refused request.
        repeat (6) step(4, 6'b0, zregs, 0, 1'b0);
        chk("fill_free_ct", 32'(bus_if.free_ct), 32'd3);
        step(4, 6'b0, zregs, 0, 1'b0);
        chk("refused_free_ct", 32'(bus_if.free_ct), 32'd3);

        // Sparse free lanes 0, 3, 5 land behind the existing entries.
        rregs = '{9, 1, 2, 12, 3, 20};
        step(0, 6'b101001, rregs, 0, 1'b0);
        chk("sparse_free_ct", 32'(bus_if.free_ct), 32'd6);
        step(3, 6'b0, zregs, 0, 1'b0);
        chk("sparse_order0", 32'(lane(0)), 32'd9);
        chk("sparse_order1", 32'(lane(1)), 32'd12);
        chk("sparse_order2", 32'(lane(2)), 32'd20);
        step(3, 6'b0, zregs, 0, 1'b0);

        // Flush together with retire.
        do_reset();
        step(4, 6'b0, zregs, 0, 1'b0);
        step(4, 6'b0, zregs, 0, 1'b0);
        step(0, 6'b0, zregs, 2, 1'b1);
        chk("flush_free_ct", 32'(bus_if.free_ct), 32'd25);
        chk("flush_lane0", 32'(lane(0)), 32'd7);
        chk("flush_spec_head", 32'(dut.spec_head_q), 32'd2);
        chk("flush_arch_head", 32'(dut.arch_head_q), 32'd2);

        // Flush blocks a same-cycle allocation.
        step(2, 6'b0, zregs, 0, 1'b1);

        // Alloc and free together with too few free registers.
        do_reset();
        repeat (6) step(4, 6'b0, zregs, 0, 1'b0);
        step(1, 6'b0, zregs, 0, 1'b0);
        rregs = '{5, 0, 0, 0, 0, 0};
        step(3, 6'b000001, rregs, 0, 1'b0);
        chk("simul_free_ct", 32'(bus_if.free_ct), 32'd3);

        // Register 10 is already on the list.
        do_reset();
        rregs = '{10, 0, 0, 0, 0, 0};
        step(0, 6'b000001, rregs, 0, 1'b0);
`ifdef FREE_LIST_DUPCHK_EN
        chk("dup_err", 32'(bus_if.err), 32'd1);
        chk("dup_free_ct", 32'(bus_if.free_ct), 32'd27);
`else
        chk("dup_err", 32'(bus_if.err), 32'd0);
        chk("dup_free_ct", 32'(bus_if.free_ct), 32'd28);
`endif
        step(0, 6'b0, zregs, 0, 1'b0);

        // Retiring more than is in flight clamps and flags.
        do_reset();
        step(1, 6'b0, zregs, 0, 1'b0);
        step(0, 6'b0, zregs, 3, 1'b0);
        chk("over_retire_err", 32'(bus_if.err), 32'd1);
        chk("over_retire_arch", 32'(dut.arch_head_q), 32'd1);
        step(0, 6'b0, zregs, 0, 1'b0);

        // Pushing six onto 27 free registers would exceed capacity.
        do_reset();
        rregs = '{0, 1, 2, 3, 4, 5};
        step(0, 6'b111111, rregs, 0, 1'b0);
`ifndef FREE_LIST_DUPCHK_EN
        chk("overflow_err", 32'(bus_if.err), 32'd1);
        chk("overflow_free_ct", 32'(bus_if.free_ct), 32'd27);
`endif

        // Randomized run: legal traffic only, many pointer wraps.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            int         a;
            int         ret;
            bit         fl;
            logic [5:0] fv;
            logic [5:0] raw;
            int         idx;
            a   = $urandom_range(0, 4);
            fl  = ($urandom_range(0, 15) == 0);
            ret = $urandom_range(0, (m_inflight.size() < 4) ? m_inflight.size() : 4);
            raw = 6'($urandom);
            fv  = '0;
            for (int k = 0; k < 6; k++) begin
                rregs[k] = $urandom_range(0, NUM_PR - 1);
                if (raw[k] && m_held.size() > 0) begin
                    idx      = $urandom_range(0, m_held.size() - 1);
                    rregs[k] = m_held[idx];
                    m_held.delete(idx);
                    fv[k]    = 1'b1;
                end
            end
            step(a, fv, rregs, ret, fl);
        end
        chk("wrap_err", 32'(bus_if.err), 32'd0);
        chk("wrap_tail_ptr", 32'(dut.tail_q), 32'((27 + m_pushed_total) % (2 * NUM_PR)));

        // Asynchronous reset mid-cycle restores state at once and drops the request.
        bus_if.alloc_ct = 3'd4;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_free_ct", 32'(bus_if.free_ct), 32'd27);
        chk("async_rst_lane0", 32'(lane(0)), 32'd5);
        chk("async_rst_err", 32'(bus_if.err), 32'd0);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        model_reset();
        #1;
        chk("post_rst_free_ct", 32'(bus_if.free_ct), 32'd27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
